load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage controller sitting directly upstream of the data memory.
- Accepts EX/MEM pipeline-register fields and drives the memory read/write ports with the correct addressing mode.
- Sign/zero-extends returned load data and holds the MEM/WB register outputs.
- Stalls upstream for one cycle per load, because memory reads are synchronous.

Parameters:
- NB_DATA_BUS, 32, data word width.
- NB_ADDRESS, 8, byte-address width into memory.
- NB_REG, 5, register-file index width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  EX/MEM slot holds an instruction.
- i_mem_read  in  1  instruction is a load.
- i_mem_write  in  1  instruction is a store.
- i_size  in  2  00 word, 01 half, 11 byte; 10 illegal.
- i_unsigned  in  1  zero-extend the load (LBU/LHU).
- i_addr  in  NB_ADDRESS  byte address (ALU result, low bits).
- i_alu_result  in  NB_DATA_BUS  non-load writeback value.
- i_store_data  in  NB_DATA_BUS  store operand, right-aligned.
- i_rd  in  NB_REG  destination register.
- i_reg_write  in  1  instruction writes the register file.
- o_r_addr / o_r_en / o_r_addressing  out  NB_ADDRESS/1/2  memory read port.
- o_w_addr / o_w_data / o_w_en / o_w_addressing  out  NB_ADDRESS/NB_DATA_BUS/1/2  memory write port.
- i_r_data  in  NB_DATA_BUS  memory read data, valid the cycle after o_r_en; addressed unit right-aligned.
- o_stall  out  1  hold EX/MEM and earlier stages.
- o_wb_valid  out  1  MEM/WB slot valid.
- o_wb_data  out  NB_DATA_BUS  writeback value.
- o_wb_rd  out  NB_REG  destination register.
- o_wb_reg_write  out  1  register-file write enable.
- o_misaligned  out  1  one-cycle pulse, alignment fault.

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE.
  - All o_wb_*, o_misaligned, o_stall, o_r_en and o_w_en are 0; address/data outputs are 0.
- Alignment check:
  - Misaligned when half and i_addr[0]=1, or word and i_addr[1:0]!=0.
  - i_size=10 is treated as misaligned.
- FSM IDLE:
  - Memory ports are driven combinationally from the inputs.
  - Store, aligned: o_w_en=1 for exactly this cycle; o_w_addressing=i_size; o_w_data=i_store_data. Next edge registers o_wb_valid=1 and o_wb_reg_write=0.
  - Load, aligned: o_r_en=1 and o_stall=1 (combinational); o_r_addressing=i_size. Next edge latches rd, size, unsigned and reg_write, clears o_wb_valid, and goes to LOAD_WAIT.
  - Neither load nor store: next edge registers o_wb_data=i_alu_result and passes rd/reg_write through; o_wb_valid=1.
  - Misaligned load/store: no memory enable is asserted. Next edge sets o_wb_valid=1, o_wb_reg_write=0, o_misaligned=1 (one cycle).
  - i_valid=0: next edge clears o_wb_valid and o_wb_reg_write.
- FSM LOAD_WAIT:
  - o_stall=0 and memory enables are 0.
  - Next edge writes o_wb_data = extension of i_r_data:
    - byte: bit 7 replicated, or zeros if unsigned.
    - half: bit 15 replicated, or zeros if unsigned.
    - word: passed through.
  - The same edge sets o_wb_valid=1, o_wb_reg_write=latched value, and returns to IDLE.
  - The EX/MEM inputs present during LOAD_WAIT are the held load; they are ignored.
- Timing:
  - Latency: 1 cycle for non-loads, 2 cycles for loads.
  - Throughput: one instruction per cycle except one bubble per load.
- Boundary cases:
  - i_mem_read and i_mem_write both high: treated as misaligned/illegal, no memory access.
  - Reset in LOAD_WAIT: load is discarded and no writeback occurs.
  - Store immediately after a load: issued in the IDLE cycle following LOAD_WAIT.

Decomposition:
- Shared package mem_pkg holds:
  - WORD/HALF/BYTE addressing codes (00/01/11), shared with the memory block.
  - State enum IDLE/LOAD_WAIT.
- One natural sub-module, load_extender: combinational size/unsigned extension of read data.

Test Plan:
- SW 0x0123ABCD @0 -> o_w_en 1 cycle, o_w_addressing=00. Then LW @0 -> o_stall 1 cycle, o_wb_data=0x0123ABCD two cycles after issue, o_wb_reg_write=1.
- LB @3 with memory returning 0x80 -> o_wb_data=0xFFFFFF80. LBU @3 -> 0x00000080.
- LH @2 returning 0x8001 -> 0xFFFF8001. LHU -> 0x00008001.
- LW @2 and SH @1 -> o_misaligned pulse, no o_r_en/o_w_en, o_wb_reg_write=0.
- Back-to-back: ADD, LW, ADD -> o_wb_valid pattern 1,0,1,1; second ADD held by o_stall for one cycle.
- Assert i_rst_n=0 during LOAD_WAIT -> all outputs 0 immediately, state IDLE, no writeback after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory addressing codes and load/store FSM states.
// Addressing codes are also decoded by the data memory block.
package mem_pkg;

    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b11;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } lsu_state_t;

    // The reserved size code 10 has no legal alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            WORD:    is_misaligned = (addr_lo != 2'b00);
            HALF:    is_misaligned = addr_lo[0];
            BYTE:    is_misaligned = 1'b0;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Sign/zero extension of right-aligned load data by access size.
module load_extender
    import mem_pkg::*;
#(
    parameter int NB_DATA_BUS = 32
) (
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic [NB_DATA_BUS-1:0] i_data,
    output logic [NB_DATA_BUS-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_size)
            BYTE: o_data = {{(NB_DATA_BUS-8){~i_unsigned & i_data[7]}}, i_data[7:0]};
            HALF: o_data = {{(NB_DATA_BUS-16){~i_unsigned & i_data[15]}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage controller: drives data-memory ports, stalls one cycle per load,
// and holds the MEM/WB register.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int NB_DATA_BUS = 32,
    parameter int NB_ADDRESS  = 8,
    parameter int NB_REG      = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic [NB_ADDRESS-1:0]  i_addr,
    input  logic [NB_DATA_BUS-1:0] i_alu_result,
    input  logic [NB_DATA_BUS-1:0] i_store_data,
    input  logic [NB_REG-1:0]      i_rd,
    input  logic                   i_reg_write,
    output logic [NB_ADDRESS-1:0]  o_r_addr,
    output logic                   o_r_en,
    output logic [1:0]             o_r_addressing,
    output logic [NB_ADDRESS-1:0]  o_w_addr,
    output logic [NB_DATA_BUS-1:0] o_w_data,
    output logic                   o_w_en,
    output logic [1:0]             o_w_addressing,
    input  logic [NB_DATA_BUS-1:0] i_r_data,
    output logic                   o_stall,
    output logic                   o_wb_valid,
    output logic [NB_DATA_BUS-1:0] o_wb_data,
    output logic [NB_REG-1:0]      o_wb_rd,
    output logic                   o_wb_reg_write,
    output logic                   o_misaligned
);

    lsu_state_t r_state, w_next;

    logic                   w_active, w_fault, w_load, w_store;
    logic [NB_DATA_BUS-1:0] w_ext_data;

    logic [NB_REG-1:0]      r_ld_rd;
    logic [1:0]             r_ld_size;
    logic                   r_ld_unsigned, r_ld_reg_write;
    logic                   r_wb_valid, r_wb_reg_write, r_misaligned;
    logic [NB_DATA_BUS-1:0] r_wb_data;
    logic [NB_REG-1:0]      r_wb_rd;

    // Reset gates the combinational port path so the memory sees nothing while held.
    assign w_active = i_rst_n && (r_state == IDLE) && i_valid;
    assign w_fault  = w_active && (i_mem_read || i_mem_write) &&
                      ((i_mem_read && i_mem_write) || is_misaligned(i_size, i_addr[1:0]));
    assign w_load   = w_active && i_mem_read  && !w_fault;
    assign w_store  = w_active && i_mem_write && !w_fault;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        o_r_en         = 1'b0;
        o_r_addr       = '0;
        o_r_addressing = 2'b00;
        o_w_en         = 1'b0;
        o_w_addr       = '0;
        o_w_data       = '0;
        o_w_addressing = 2'b00;
        o_stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    o_r_en         = 1'b1;
                    o_r_addr       = i_addr;
                    o_r_addressing = i_size;
                    o_stall        = 1'b1;
                    w_next         = LOAD_WAIT;
                end
                if (w_store) begin
                    o_w_en         = 1'b1;
                    o_w_addr       = i_addr;
                    o_w_data       = i_store_data;
                    o_w_addressing = i_size;
                end
            end
            LOAD_WAIT: w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    load_extender #(.NB_DATA_BUS(NB_DATA_BUS)) u_ext (
        .i_size     (r_ld_size),
        .i_unsigned (r_ld_unsigned),
        .i_data     (i_r_data),
        .o_data     (w_ext_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_rd        <= '0;
            r_ld_size      <= 2'b00;
            r_ld_unsigned  <= 1'b0;
            r_ld_reg_write <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= '0;
            r_wb_rd        <= '0;
            r_misaligned   <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            if (r_state == LOAD_WAIT) begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= w_ext_data;
                r_wb_rd        <= r_ld_rd;
                r_wb_reg_write <= r_ld_reg_write;
            end else if (!i_valid) begin
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
            end else if (w_fault) begin
                r_wb_valid     <= 1'b1;
                r_wb_reg_write <= 1'b0;
                r_wb_rd        <= i_rd;
                r_misaligned   <= 1'b1;
            end else if (w_load) begin
                r_ld_rd        <= i_rd;
                r_ld_size      <= i_size;
                r_ld_unsigned  <= i_unsigned;
                r_ld_reg_write <= i_reg_write;
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
            end else if (w_store) begin
                r_wb_valid     <= 1'b1;
                r_wb_reg_write <= 1'b0;
                r_wb_rd        <= i_rd;
            end else begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= i_alu_result;
                r_wb_rd        <= i_rd;
                r_wb_reg_write <= i_reg_write;
            end
        end
    end

    assign o_wb_valid     = r_wb_valid;
    assign o_wb_data      = r_wb_data;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_reg_write = r_wb_reg_write;
    assign o_misaligned   = r_misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench: byte-array data memory on the DUT ports plus an
// instruction-level reference model with its own shadow memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid, mem_read, mem_write, uns, reg_write;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd;
    logic [7:0]  r_addr, w_addr;
    logic        r_en, w_en, stall, wb_valid, wb_reg_write, misaligned;
    logic [1:0]  r_addressing, w_addressing;
    logic [31:0] w_data, r_data, wb_data;
    logic [4:0]  wb_rd;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] dmem  [256];
    logic [7:0] model [256];

    always #5 clk = ~clk;

    load_store_unit #(.NB_DATA_BUS(32), .NB_ADDRESS(8), .NB_REG(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_size(size), .i_unsigned(uns), .i_addr(addr),
        .i_alu_result(alu_result), .i_store_data(store_data), .i_rd(rd),
        .i_reg_write(reg_write), .o_r_addr(r_addr), .o_r_en(r_en),
        .o_r_addressing(r_addressing), .o_w_addr(w_addr), .o_w_data(w_data),
        .o_w_en(w_en), .o_w_addressing(w_addressing), .i_r_data(r_data),
        .o_stall(stall), .o_wb_valid(wb_valid), .o_wb_data(wb_data),
        .o_wb_rd(wb_rd), .o_wb_reg_write(wb_reg_write), .o_misaligned(misaligned)
    );

    // Synchronous little-endian memory; the addressed unit comes back right-aligned.
    always @(posedge clk) begin
        if (r_en) begin
            case (r_addressing)
                2'b11:   r_data <= {24'h0, dmem[r_addr]};
                2'b01:   r_data <= {16'h0, dmem[r_addr+8'd1], dmem[r_addr]};
                default: r_data <= {dmem[r_addr+8'd3], dmem[r_addr+8'd2], dmem[r_addr+8'd1], dmem[r_addr]};
            endcase
        end
        if (w_en) begin
            dmem[w_addr] <= w_data[7:0];
            if (w_addressing != 2'b11) dmem[w_addr+8'd1] <= w_data[15:8];
            if (w_addressing == 2'b00) begin
                dmem[w_addr+8'd2] <= w_data[23:16];
                dmem[w_addr+8'd3] <= w_data[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int unit_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [7:0] a);
        longint v = 0;
        int n = unit_bytes(sz);
        for (int i = n - 1; i >= 0; i--) v = v * 256 + model[8'(a + i)];
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // One instruction through the stage, checking ports mid-cycle and MEM/WB after each edge.
    task automatic issue(input logic v, input logic ld_i, input logic st_i, input logic [1:0] sz,
                         input logic u, input logic [7:0] a, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rdx, input logic rw);
        logic bad, ld, st;
        valid = v; mem_read = ld_i; mem_write = st_i; size = sz; uns = u; addr = a;
        alu_result = alu; store_data = sd; rd = rdx; reg_write = rw;
        bad = v && (ld_i || st_i) && ((ld_i && st_i) || sz == 2'b10 ||
              (sz == 2'b00 && a % 4 != 0) || (sz == 2'b01 && a % 2 != 0));
        ld = v && ld_i && !bad;
        st = v && st_i && !bad;
        #4;
        chk("r_en", r_en, ld);
        chk("stall", stall, ld);
        chk("w_en", w_en, st);
        if (ld) begin
            chk("r_addr", r_addr, a);
            chk("r_addressing", r_addressing, sz);
        end
        if (st) begin
            chk("w_addr", w_addr, a);
            chk("w_addressing", w_addressing, sz);
            chk("w_data", w_data, sd);
            for (int i = 0; i < unit_bytes(sz); i++) model[8'(a + i)] = sd[8*i +: 8];
        end
        @(posedge clk); #1;
        if (ld) begin
            chk("ld_bubble_valid", wb_valid, 0);
            #3;
            chk("wait_stall", stall, 0);
            chk("wait_r_en", r_en, 0);
            chk("wait_w_en", w_en, 0);
            @(posedge clk); #1;
            chk("ld_data", wb_data, model_load(sz, u, a));
            chk("ld_valid", wb_valid, 1);
            chk("ld_rw", wb_reg_write, rw);
            chk("ld_rd", wb_rd, rdx);
            chk("ld_mis", misaligned, 0);
        end else if (!v) begin
            chk("idle_valid", wb_valid, 0);
            chk("idle_rw", wb_reg_write, 0);
        end else if (bad) begin
            chk("mis_valid", wb_valid, 1);
            chk("mis_rw", wb_reg_write, 0);
            chk("mis_pulse", misaligned, 1);
        end else if (st) begin
            chk("st_valid", wb_valid, 1);
            chk("st_rw", wb_reg_write, 0);
            chk("st_mis", misaligned, 0);
        end else begin
            chk("alu_data", wb_data, alu);
            chk("alu_rd", wb_rd, rdx);
            chk("alu_rw", wb_reg_write, rw);
            chk("alu_valid", wb_valid, 1);
            chk("alu_mis", misaligned, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        valid = 0; mem_read = 0; mem_write = 0; size = 0; uns = 0; addr = 0;
        alu_result = 0; store_data = 0; rd = 0; reg_write = 0; r_data = 0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        #12;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_stall", stall, 0);
        chk("rst_misaligned", misaligned, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Zero the region the random loads touch, through the DUT.
        for (int i = 0; i < 20; i += 4) issue(1, 0, 1, 2'b00, 0, 8'(i), 0, 0, 0, 0);

        issue(1, 0, 1, 2'b00, 0, 8'd0, 0, 32'h0123ABCD, 5'd1, 1);
        issue(1, 1, 0, 2'b00, 0, 8'd0, 0, 0, 5'd2, 1);
        issue(1, 0, 1, 2'b11, 0, 8'd3, 0, 32'h00000080, 5'd0, 0);
        issue(1, 1, 0, 2'b11, 0, 8'd3, 0, 0, 5'd3, 1);
        issue(1, 1, 0, 2'b11, 1, 8'd3, 0, 0, 5'd4, 1);
        issue(1, 0, 1, 2'b01, 0, 8'd2, 0, 32'hFFFF8001, 5'd0, 0);
        issue(1, 1, 0, 2'b01, 0, 8'd2, 0, 0, 5'd5, 1);
        issue(1, 1, 0, 2'b01, 1, 8'd2, 0, 0, 5'd6, 1);
        issue(1, 1, 0, 2'b00, 0, 8'd2, 0, 0, 5'd7, 1);
        issue(1, 0, 1, 2'b01, 0, 8'd1, 0, 32'h1234, 5'd0, 0);
        issue(1, 1, 1, 2'b00, 0, 8'd0, 0, 0, 5'd8, 1);
        issue(1, 0, 0, 2'b00, 0, 8'd0, 32'hDEAD0001, 0, 5'd9, 1);
        issue(1, 1, 0, 2'b00, 0, 8'd4, 0, 0, 5'd10, 1);
        issue(1, 0, 0, 2'b00, 0, 8'd0, 32'hDEAD0002, 0, 5'd11, 1);
        issue(1, 1, 0, 2'b00, 0, 8'd0, 0, 0, 5'd12, 1);
        issue(1, 0, 1, 2'b00, 0, 8'd8, 0, 32'hCAFEF00D, 5'd0, 0);

        // Reset while a load is waiting: outputs clear at once, no writeback follows.
        valid = 1; mem_read = 1; mem_write = 0; size = 2'b00; addr = 8'd0; rd = 5'd13; reg_write = 1;
        @(posedge clk); #3;
        rst_n = 0; #1;
        chk("rst_lw_stall", stall, 0);
        chk("rst_lw_r_en", r_en, 0);
        chk("rst_lw_r_addr", r_addr, 0);
        chk("rst_lw_wb_valid", wb_valid, 0);
        chk("rst_lw_wb_rw", wb_reg_write, 0);
        valid = 0; mem_read = 0;
        #6 rst_n = 1;
        @(posedge clk); #1;
        chk("rst_lw_no_wb", wb_valid, 0);
        @(posedge clk); #1;
        chk("rst_lw_no_wb2", wb_reg_write, 0);

        for (int n = 0; n < 400; n++) begin
            int k = $urandom_range(0, 9);
            int s = $urandom_range(0, 9);
            logic [1:0] sz = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b11 : 2'b10;
            issue(k != 8, k inside {[3:5], 9}, k inside {[6:7], 9}, sz, 1'($urandom),
                  8'($urandom_range(0, 16)), $urandom, $urandom, 5'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
